// File: rtl/shift_row_pipe.sv
// Registered AES ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8 columns.
// The row rotation is applied on the way in; each transformed beat is buffered in a small FIFO.
module shift_row_pipe #(
    parameter int NB    = 4,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_inverse,
    input  logic [7:0]                   state_array_in  [0:4*NB-1],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   state_array_out [0:4*NB-1],
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    input  logic                         clear
);

    localparam int NBYTES = 4 * NB;
    localparam int OW     = $clog2(DEPTH + 1);
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_row_pipe: NB must be 4, 6 or 8");
        end
        if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
            $error("shift_row_pipe: DEPTH must be in 1..8");
        end
    endgenerate

    // Rijndael row offsets: rows 2 and 3 shift one further for the 256-bit block.
    function automatic int row_off(input int r);
        if (NB == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    function automatic int src_col(input int c, input int r, input logic inv);
        if (inv) return (c - row_off(r) + NB) % NB;
        return (c + row_off(r)) % NB;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    logic [7:0]    shifted [0:NBYTES-1];
    logic [7:0]    mem_q   [0:DEPTH-1][0:NBYTES-1];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          push, pop;

    always_comb begin
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[4*c + r] = state_array_in[4*src_col(c, r, in_inverse) + r];
            end
        end
    end

    assign in_ready  = (occ_q < OW'(DEPTH));
    assign out_valid = (occ_q != '0);
    assign occupancy = occ_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        for (int i = 0; i < NBYTES; i++) begin
            state_array_out[i] = mem_q[rd_ptr_q][i];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage is cleared by reset so an idle output reads as zeros; clear only
    // rewinds the pointers and drops any beat pushed in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                for (int i = 0; i < NBYTES; i++) begin
                    mem_q[d][i] <= 8'h00;
                end
            end
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push) begin
                for (int i = 0; i < NBYTES; i++) begin
                    mem_q[wr_ptr_q][i] <= shifted[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_row_pipe.sv
// Self-checking bench for shift_row_pipe: NB=4/6/8 instances against a row-rotation reference model.
module tb_shift_row_pipe;

    typedef logic [7:0] st_t [0:31];

    logic clk = 1'b0;
    logic rst, clear;
    always #5 clk = ~clk;

    logic v4, inv4, ordy4, ir4, ov4;
    logic [1:0] occ4;
    logic [7:0] din4 [0:15];
    logic [7:0] dout4 [0:15];
    logic v6, inv6, ordy6, ir6, ov6;
    logic [1:0] occ6;
    logic [7:0] din6 [0:23];
    logic [7:0] dout6 [0:23];
    logic v8, inv8, ordy8, ir8, ov8;
    logic [1:0] occ8;
    logic [7:0] din8 [0:31];
    logic [7:0] dout8 [0:31];

    int checks = 0;
    int failures = 0;

    logic [7:0] inv_exp [0:15] = '{8'd0, 8'd13, 8'd10, 8'd7, 8'd4, 8'd1, 8'd14, 8'd11,
                                   8'd8, 8'd5, 8'd2, 8'd15, 8'd12, 8'd9, 8'd6, 8'd3};
    logic [7:0] fwd_exp [0:15] = '{8'd0, 8'd5, 8'd10, 8'd15, 8'd4, 8'd9, 8'd14, 8'd3,
                                   8'd8, 8'd13, 8'd2, 8'd7, 8'd12, 8'd1, 8'd6, 8'd11};

    shift_row_pipe #(.NB(4), .DEPTH(2)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_inverse(inv4),
        .state_array_in(din4), .out_valid(ov4), .out_ready(ordy4),
        .state_array_out(dout4), .occupancy(occ4), .clear(clear));
    shift_row_pipe #(.NB(6), .DEPTH(2)) u6 (
        .clk(clk), .rst(rst), .in_valid(v6), .in_ready(ir6), .in_inverse(inv6),
        .state_array_in(din6), .out_valid(ov6), .out_ready(ordy6),
        .state_array_out(dout6), .occupancy(occ6), .clear(clear));
    shift_row_pipe #(.NB(8), .DEPTH(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in_inverse(inv8),
        .state_array_in(din8), .out_valid(ov8), .out_ready(ordy8),
        .state_array_out(dout8), .occupancy(occ8), .clear(clear));

    // Reference: each row r is rotated left (forward) or right (inverse) by its offset.
    function automatic st_t shift_ref(input st_t s, input int nb, input bit inv);
        st_t o;
        logic [7:0] row [0:7];
        int k;
        o = s;
        for (int r = 0; r < 4; r++) begin
            k = (nb == 8 && r >= 2) ? r + 1 : r;
            for (int c = 0; c < nb; c++) row[c] = s[4*c + r];
            for (int c = 0; c < nb; c++)
                o[4*c + r] = inv ? row[(c - k + nb) % nb] : row[(c + k) % nb];
        end
        return o;
    endfunction

    function automatic st_t rand_state(input int nb);
        st_t s;
        for (int i = 0; i < 32; i++) s[i] = (i < 4*nb) ? 8'($urandom) : 8'h00;
        return s;
    endfunction

    function automatic st_t ramp_state(input int nb);
        st_t s;
        for (int i = 0; i < 32; i++) s[i] = (i < 4*nb) ? 8'(i) : 8'h00;
        return s;
    endfunction

    function automatic int first_diff(input st_t a, input st_t b, input int n);
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic set_in(input int nb, input st_t s);
        case (nb)
            4: for (int i = 0; i < 16; i++) din4[i] = s[i];
            6: for (int i = 0; i < 24; i++) din6[i] = s[i];
            default: for (int i = 0; i < 32; i++) din8[i] = s[i];
        endcase
    endtask

    function automatic st_t get_out(input int nb);
        st_t o;
        for (int i = 0; i < 32; i++) o[i] = 8'h00;
        case (nb)
            4: for (int i = 0; i < 16; i++) o[i] = dout4[i];
            6: for (int i = 0; i < 24; i++) o[i] = dout6[i];
            default: for (int i = 0; i < 32; i++) o[i] = dout8[i];
        endcase
        return o;
    endfunction

    task automatic set_ctl(input int nb, input logic v, input logic inv);
        case (nb)
            4: begin v4 = v; inv4 = inv; end
            6: begin v6 = v; inv6 = inv; end
            default: begin v8 = v; inv8 = inv; end
        endcase
    endtask

    function automatic logic get_ov(input int nb);
        case (nb)
            4: return ov4;
            6: return ov6;
            default: return ov8;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        st_t z;
        int d;
        for (int i = 0; i < 32; i++) z[i] = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ov4 !== 1'b0 || ov6 !== 1'b0 || ov8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b/%b/%b want 0/0/0", ov4, ov6, ov8);
        end
        checks++;
        if (occ4 !== 2'd0 || ir4 !== 1'b1) begin
            failures++;
            $display("FAIL reset_occ_ready: got occ=%0d in_ready=%b want occ=0 in_ready=1", occ4, ir4);
        end
        d = first_diff(get_out(8), z, 32);
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL reset_data_zero: byte %0d got %0d want 0", d, dout8[d]);
        end
    endtask

    task automatic test_inverse_vector();
        st_t s, e;
        int d;
        s = ramp_state(4);
        for (int i = 0; i < 32; i++) e[i] = (i < 16) ? inv_exp[i] : 8'h00;
        set_in(4, s);
        set_ctl(4, 1'b1, 1'b1);
        ordy4 = 1'b1;
        checks++;
        if (ov4 !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass: out_valid got %b want 0 before edge", ov4);
        end
        tick();
        set_ctl(4, 1'b0, 1'b0);
        checks++;
        if (ov4 !== 1'b1 || occ4 !== 2'd1) begin
            failures++;
            $display("FAIL inv_latency: out_valid=%b occ=%0d want 1/1", ov4, occ4);
        end
        d = first_diff(get_out(4), e, 16);
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL inv_vector: byte %0d got %0d want %0d", d, dout4[d], e[d]);
        end
        tick();
        checks++;
        if (ov4 !== 1'b0 || occ4 !== 2'd0) begin
            failures++;
            $display("FAIL inv_drain: out_valid=%b occ=%0d want 0/0", ov4, occ4);
        end
    endtask

    task automatic test_forward_roundtrip();
        st_t s, e, o;
        int d;
        s = ramp_state(4);
        for (int i = 0; i < 32; i++) e[i] = (i < 16) ? fwd_exp[i] : 8'h00;
        set_in(4, s);
        set_ctl(4, 1'b1, 1'b0);
        ordy4 = 1'b1;
        tick();
        o = get_out(4);
        d = first_diff(o, e, 16);
        checks++;
        if (ov4 !== 1'b1 || d >= 0) begin
            failures++;
            $display("FAIL fwd_vector: out_valid=%b byte %0d got %0d want %0d", ov4, d, (d >= 0) ? o[d] : 8'h0, (d >= 0) ? e[d] : 8'h0);
        end
        set_in(4, o);
        set_ctl(4, 1'b1, 1'b1);
        tick();
        set_ctl(4, 1'b0, 1'b0);
        o = get_out(4);
        d = first_diff(o, s, 16);
        checks++;
        if (ov4 !== 1'b1 || d >= 0) begin
            failures++;
            $display("FAIL fwd_inv_identity: out_valid=%b byte %0d got %0d want %0d", ov4, d, (d >= 0) ? o[d] : 8'h0, (d >= 0) ? s[d] : 8'h0);
        end
        tick();
    endtask

    task automatic test_nb8_vector();
        st_t s, o;
        logic [7:0] lo [0:3];
        logic [7:0] hi [0:3];
        logic [7:0] w_lo [0:3] = '{8'd0, 8'd5, 8'd14, 8'd19};
        logic [7:0] w_hi [0:3] = '{8'd28, 8'd1, 8'd10, 8'd15};
        s = ramp_state(8);
        set_in(8, s);
        set_ctl(8, 1'b1, 1'b0);
        tick();
        set_ctl(8, 1'b0, 1'b0);
        o = get_out(8);
        for (int i = 0; i < 4; i++) begin
            lo[i] = o[i];
            hi[i] = o[28 + i];
        end
        checks++;
        if (ov8 !== 1'b1 || lo != w_lo || hi != w_hi) begin
            failures++;
            $display("FAIL nb8_vector: out_valid=%b out[0..3]=%0d,%0d,%0d,%0d out[28..31]=%0d,%0d,%0d,%0d want 0,5,14,19 / 28,1,10,15",
                     ov8, lo[0], lo[1], lo[2], lo[3], hi[0], hi[1], hi[2], hi[3]);
        end
        tick();
    endtask

    task automatic test_roundtrip();
        st_t s, o1, o2, e;
        int d;
        int nbs [0:2] = '{4, 6, 8};
        ordy4 = 1'b1;
        for (int n = 0; n < 3; n++) begin
            for (int it = 0; it < 3; it++) begin
                s = rand_state(nbs[n]);
                e = shift_ref(s, nbs[n], 1'b0);
                set_in(nbs[n], s);
                set_ctl(nbs[n], 1'b1, 1'b0);
                tick();
                o1 = get_out(nbs[n]);
                d = first_diff(o1, e, 4*nbs[n]);
                checks++;
                if (get_ov(nbs[n]) !== 1'b1 || d >= 0) begin
                    failures++;
                    $display("FAIL rt_forward nb=%0d: byte %0d got %0d want %0d", nbs[n], d, (d >= 0) ? o1[d] : 8'h0, (d >= 0) ? e[d] : 8'h0);
                end
                set_in(nbs[n], o1);
                set_ctl(nbs[n], 1'b1, 1'b1);
                tick();
                set_ctl(nbs[n], 1'b0, 1'b0);
                o2 = get_out(nbs[n]);
                d = first_diff(o2, s, 4*nbs[n]);
                checks++;
                if (get_ov(nbs[n]) !== 1'b1 || d >= 0) begin
                    failures++;
                    $display("FAIL rt_identity nb=%0d: byte %0d got %0d want %0d", nbs[n], d, (d >= 0) ? o2[d] : 8'h0, (d >= 0) ? s[d] : 8'h0);
                end
                tick();
            end
        end
    endtask

    task automatic test_backpressure();
        st_t a, b, c, o, ea, eb, ec;
        int d;
        a = rand_state(4); b = rand_state(4); c = rand_state(4);
        ea = shift_ref(a, 4, 1'b0); eb = shift_ref(b, 4, 1'b1); ec = shift_ref(c, 4, 1'b0);
        ordy4 = 1'b0;
        set_in(4, a); set_ctl(4, 1'b1, 1'b0);
        tick();
        set_in(4, b); set_ctl(4, 1'b1, 1'b1);
        tick();
        set_in(4, c); set_ctl(4, 1'b1, 1'b0);
        checks++;
        if (occ4 !== 2'd2 || ir4 !== 1'b0 || ov4 !== 1'b1) begin
            failures++;
            $display("FAIL bp_full: occ=%0d in_ready=%b out_valid=%b want 2/0/1", occ4, ir4, ov4);
        end
        tick();
        o = get_out(4);
        d = first_diff(o, ea, 16);
        checks++;
        if (occ4 !== 2'd2 || ir4 !== 1'b0 || d >= 0) begin
            failures++;
            $display("FAIL bp_hold: occ=%0d in_ready=%b head byte %0d got %0d want %0d", occ4, ir4, d, (d >= 0) ? o[d] : 8'h0, (d >= 0) ? ea[d] : 8'h0);
        end
        ordy4 = 1'b1;
        tick();
        o = get_out(4);
        d = first_diff(o, eb, 16);
        checks++;
        if (occ4 !== 2'd1 || ir4 !== 1'b1 || d >= 0) begin
            failures++;
            $display("FAIL bp_pop1: occ=%0d in_ready=%b head byte %0d got %0d want %0d", occ4, ir4, d, (d >= 0) ? o[d] : 8'h0, (d >= 0) ? eb[d] : 8'h0);
        end
        tick();
        set_ctl(4, 1'b0, 1'b0);
        o = get_out(4);
        d = first_diff(o, ec, 16);
        checks++;
        if (occ4 !== 2'd1 || ov4 !== 1'b1 || d >= 0) begin
            failures++;
            $display("FAIL bp_third: occ=%0d out_valid=%b head byte %0d got %0d want %0d", occ4, ov4, d, (d >= 0) ? o[d] : 8'h0, (d >= 0) ? ec[d] : 8'h0);
        end
        tick();
        checks++;
        if (occ4 !== 2'd0 || ov4 !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: occ=%0d out_valid=%b want 0/0", occ4, ov4);
        end
    endtask

    task automatic test_back_to_back();
        st_t q [$];
        st_t cur, e, o;
        int sent = 0;
        int pops = 0;
        int d;
        logic mode;
        ordy4 = 1'b1;
        for (int cyc = 0; cyc < 21; cyc++) begin
            if (sent < 20) begin
                cur = rand_state(4);
                mode = 1'($urandom);
                set_in(4, cur);
                set_ctl(4, 1'b1, mode);
            end else begin
                set_ctl(4, 1'b0, 1'b0);
            end
            checks++;
            if (occ4 > 2'd1) begin
                failures++;
                $display("FAIL b2b_occ: cycle %0d occ=%0d want <=1", cyc, occ4);
            end
            if (ov4 === 1'b1) begin
                o = get_out(4);
                e = (q.size() > 0) ? q.pop_front() : o;
                d = first_diff(o, e, 16);
                pops++;
                checks++;
                if (d >= 0) begin
                    failures++;
                    $display("FAIL b2b_data: pop %0d byte %0d got %0d want %0d", pops, d, o[d], e[d]);
                end
            end
            if (v4 === 1'b1 && ir4 === 1'b1) begin
                q.push_back(shift_ref(cur, 4, mode));
                sent++;
            end
            tick();
        end
        set_ctl(4, 1'b0, 1'b0);
        checks++;
        if (pops != 20 || sent != 20 || ov4 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count: pops=%0d sent=%0d out_valid=%b want 20/20/0", pops, sent, ov4);
        end
    endtask

    task automatic test_random();
        st_t q [$];
        st_t cur, o;
        logic mode;
        logic push, pop;
        logic hold = 1'b0;
        int d;
        int bad = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin
                cur = rand_state(4);
                mode = 1'($urandom);
                set_in(4, cur);
                set_ctl(4, ($urandom % 4) != 0, mode);
            end
            ordy4 = ($urandom % 3) != 0;
            checks++;
            if (occ4 !== 2'(q.size()) || ir4 !== (q.size() < 2) || ov4 !== (q.size() != 0)) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL rand_ctrl: cycle %0d occ=%0d in_ready=%b out_valid=%b want occ=%0d", cyc, occ4, ir4, ov4, q.size());
            end
            if (q.size() != 0) begin
                o = get_out(4);
                d = first_diff(o, q[0], 16);
                checks++;
                if (d >= 0) begin
                    failures++; bad++;
                    if (bad < 5) $display("FAIL rand_data: cycle %0d byte %0d got %0d want %0d", cyc, d, o[d], q[0][d]);
                end
            end
            push = v4 && (q.size() < 2);
            pop  = (q.size() != 0) && ordy4;
            tick();
            if (pop) void'(q.pop_front());
            if (push) q.push_back(shift_ref(cur, 4, mode));
            hold = v4 && !push;
        end
        set_ctl(4, 1'b0, 1'b0);
        ordy4 = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_flush();
        st_t z, o;
        int d;
        for (int i = 0; i < 32; i++) z[i] = 8'h00;
        ordy4 = 1'b0;
        set_in(4, rand_state(4)); set_ctl(4, 1'b1, 1'b0);
        tick();
        set_in(4, rand_state(4)); set_ctl(4, 1'b1, 1'b1);
        tick();
        set_ctl(4, 1'b0, 1'b0);
        checks++;
        if (occ4 !== 2'd2) begin
            failures++;
            $display("FAIL flush_fill: occ=%0d want 2", occ4);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        o = get_out(4);
        d = first_diff(o, z, 16);
        checks++;
        if (ov4 !== 1'b0 || occ4 !== 2'd0 || ir4 !== 1'b1 || d >= 0) begin
            failures++;
            $display("FAIL rst_flush: out_valid=%b occ=%0d in_ready=%b zero-byte-diff=%0d want 0/0/1/-1", ov4, occ4, ir4, d);
        end
        set_in(4, rand_state(4)); set_ctl(4, 1'b1, 1'b0);
        tick();
        set_in(4, rand_state(4)); set_ctl(4, 1'b1, 1'b1);
        clear = 1'b1;
        checks++;
        if (ir4 !== 1'b1 || occ4 !== 2'd1) begin
            failures++;
            $display("FAIL clear_pre: in_ready=%b occ=%0d want 1/1", ir4, occ4);
        end
        tick();
        clear = 1'b0;
        set_ctl(4, 1'b0, 1'b0);
        ordy4 = 1'b1;
        checks++;
        if (ov4 !== 1'b0 || occ4 !== 2'd0 || ir4 !== 1'b1) begin
            failures++;
            $display("FAIL clear_flush: out_valid=%b occ=%0d in_ready=%b want 0/0/1", ov4, occ4, ir4);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ov4 !== 1'b0) begin
                failures++;
                $display("FAIL clear_discard: cycle %0d out_valid=%b want 0", i, ov4);
            end
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        v4 = 1'b0; inv4 = 1'b0; ordy4 = 1'b1;
        v6 = 1'b0; inv6 = 1'b0; ordy6 = 1'b1;
        v8 = 1'b0; inv8 = 1'b0; ordy8 = 1'b1;
        for (int i = 0; i < 16; i++) din4[i] = 8'h00;
        for (int i = 0; i < 24; i++) din6[i] = 8'h00;
        for (int i = 0; i < 32; i++) din8[i] = 8'h00;
        tick();
        test_reset();
        test_inverse_vector();
        test_forward_roundtrip();
        test_nb8_vector();
        test_roundtrip();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_row_pipe.md
Name: shift_row_pipe

Overview:
- Parametrised, registered ShiftRows/InvShiftRows stage for the AES/Rijndael datapath.
- Supports block widths Nb = 4, 6 or 8 columns and a per-beat forward/inverse mode, so one instance serves both the encrypt and decrypt round pipelines.
- Sits between SubBytes and MixColumns (or their inverses).
- Each beat is buffered in a small FIFO behind a valid/ready handshake, decoupling the round stages.

Parameters:
- NB, 4, number of state columns; legal values 4, 6, 8; any other value is an elaboration error.
- DEPTH, 2, number of buffered beats; legal values 1..8. DEPTH=2 is required for full throughput.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept a beat this cycle
- in_inverse  input  1  0 = forward ShiftRows, 1 = InvShiftRows; sampled with the beat
- state_array_in  input  [7:0] x [0:4*NB-1]  input state, column-major, byte index = 4*c + r
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts the beat
- state_array_out  output  [7:0] x [0:4*NB-1]  shifted state, same byte ordering
- occupancy  output  $clog2(DEPTH+1)  number of buffered beats
- clear  input  1  synchronous flush of all buffered beats

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high, sampled on the rising edge of clk.
- Row offsets off[r] for r = 0..3:
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Transform, for r in 0..3 and c in 0..NB-1:
  - Forward: out[4c+r] = in[4*((c+off[r]) mod NB) + r].
  - Inverse: out[4c+r] = in[4*((c-off[r]+NB) mod NB) + r].
  - Row 0 is never moved.
  - The transform is purely combinational on the input side. The transformed state is written into the FIFO entry, so the mode is fixed per beat.
- Handshake:
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready = (occupancy < DEPTH). It does not depend on out_ready (no combinational path from out_ready to in_ready).
  - out_valid = (occupancy != 0).
  - state_array_out always shows the head entry.
  - in_valid may be asserted with in_ready low; such a beat is not consumed, and the source must hold it stable.
- Latency:
  - A beat pushed in cycle N appears with out_valid=1 in cycle N+1 at the earliest.
  - No same-cycle bypass.
- Throughput:
  - With DEPTH >= 2 and out_ready held high, one beat per cycle is sustained.
  - With DEPTH = 1, at most one beat every 2 cycles.
- FIFO:
  - Circular buffer with read/write pointers that wrap from DEPTH-1 to 0.
  - Occupancy update rules:
    - Push only: +1.
    - Pop only: -1.
    - Push and pop together: unchanged. The head advances and the new beat is written at the tail.
    - When full, push is blocked, but a pop in the same cycle is still honoured. in_ready rises the following cycle.
    - When empty, a pop cannot occur.
- clear:
  - Next cycle: occupancy = 0, pointers = 0, out_valid = 0.
  - A push presented in the same cycle as clear is discarded. in_ready is unaffected by clear in that cycle.
  - clear has lower priority than rst.
- Reset:
  - Next cycle: occupancy = 0, pointers = 0, out_valid = 0, in_ready = 1.
  - All storage entries = 0, so state_array_out = all zeros.
  - Asserting rst mid-stream drops every buffered beat.
  - A beat held under out_valid is lost without being popped. Downstream must not count it.
- Empty-state output: state_array_out holds the stale head entry (zeros after reset). Consumers must qualify data with out_valid.

Test Plan:
- NB=4, inverse, in[i]=i, out_ready=1 -> one cycle later out_valid=1 and out = 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
- NB=4, forward, in[i]=i -> out = 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11. Then apply inverse on that result -> original 0..15 restored.
- NB=8, forward, in[i]=i -> out[0..3] = 0,5,14,19 and out[28..31] = 28,1,10,15. A forward-then-inverse round trip returns the identity for NB=4, 6 and 8.
- DEPTH=2, out_ready=0, three back-to-back beats -> two accepted, occupancy=2, in_ready=0, third held by the source. Raise out_ready -> beats popped in order with alternating mode preserved per beat. The third beat is accepted the cycle after the first pop.
- Continuous in_valid=1 and out_ready=1 for 20 beats -> 20 pops in 21 cycles, occupancy never exceeds 1, pointers wrap without loss or duplication.
- With occupancy=2, assert rst (and separately clear, with a simultaneous push) -> next cycle out_valid=0, occupancy=0, in_ready=1. After rst, state_array_out = 0. The pushed beat never emerges.
